// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the seven-segment scan controller:
//                hex-to-segment table, blank pattern and drive polarities.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Every segment and the decimal point dark
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low drive levels for segments and digit anodes
    localparam logic c_seg_lit  = 1'b0;
    localparam logic c_seg_dark = 1'b1;
    localparam logic c_an_on    = 1'b0;
    localparam logic c_an_off   = 1'b1;

    // Sixteen 8-bit entries, entry n at bits [8n+7:8n]; bit 7 (dp) is dark,
    // bits 6..0 are g..a, active-low.
    localparam logic [127:0] c_hex_seg = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex nibble to active-low segment decoder with
//                decimal point and per-digit blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Table lookup, then overlay the dp bit; blanking overrides everything
    always_comb begin
        o_seg    = c_hex_seg[{i_nibble, 3'b000} +: 8];
        o_seg[7] = i_dp ? c_seg_lit : c_seg_dark;
        if (i_blank) begin
            o_seg = SEG_OFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Multiplexed seven-segment display scanner with page select,
//                frame snapshots (tear-free), leading-zero blanking and a
//                global blank. Outputs are registered and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_PAGES  = 2,
    parameter int DIV_TERM   = 262144
) (
    input  logic                                                 CLK,
    input  logic                                                 RST,
    input  logic [4*NUM_DIGITS*NUM_PAGES-1:0]                    Data,
    input  logic [((NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1)-1:0] Sel,
    input  logic [NUM_DIGITS-1:0]                                Dp,
    input  logic                                                 LzbEn,
    input  logic                                                 Blank,
    output logic [NUM_DIGITS-1:0]                                AN,
    output logic [7:0]                                           Seg,
    output logic                                                 FrameStart
);

    localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_cnt_w  = $clog2(DIV_TERM);
    localparam int c_page_w = 4 * NUM_DIGITS;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_TERM - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    logic [c_cnt_w-1:0]    r_div_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_first;
    logic                  r_valid;
    logic [c_page_w-1:0]   r_snap_data;
    logic [NUM_DIGITS-1:0] r_snap_dp;
    logic                  r_snap_lzb;
    logic                  r_snap_void;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_seg;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_load;
    logic [c_page_w-1:0]   w_page;
    logic                  w_sel_ok;
    logic [c_page_w-1:0]   w_shifted;
    logic                  w_lzb_blank;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an_drive;
    logic [7:0]            w_seg_dec;

    assign w_tick = (r_div_cnt == c_cnt_last);
    assign w_wrap = w_tick && (r_idx == c_idx_last);
    // A new frame starts right after reset and whenever the scan wraps to digit 0
    assign w_load = r_first || w_wrap;

    // Prescaler: free-running 0..DIV_TERM-1
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Digit index: advance one slot per tick, wrap after the last digit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Page mux; an out-of-range select yields a void (all-blank) frame
    always_comb begin
        w_page   = '0;
        w_sel_ok = (int'(Sel) < NUM_PAGES);
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (int'(Sel) == p) begin
                w_page = Data[p*c_page_w +: c_page_w];
            end
        end
    end

    // Frame snapshot: inputs are captured only at frame boundaries so a frame never tears
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_first     <= 1'b1;
            r_valid     <= 1'b0;
            r_snap_data <= '0;
            r_snap_dp   <= '0;
            r_snap_lzb  <= 1'b0;
            r_snap_void <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (w_load) begin
                r_valid     <= 1'b1;
                r_snap_data <= w_page;
                r_snap_dp   <= Dp;
                r_snap_lzb  <= LzbEn;
                r_snap_void <= !w_sel_ok;
            end
        end
    end

    // Current digit: nibble is the low end of the shifted page, and the digit is
    // a leading zero when it and everything above it are zero
    always_comb begin
        w_shifted   = r_snap_data >> {r_idx, 2'b00};
        w_lzb_blank = r_snap_lzb && (r_idx != '0) && (w_shifted == '0);
        w_dp        = 1'b0;
        w_an_drive  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_drive[i] = (int'(r_idx) == i) ? c_an_on : c_an_off;
            if (int'(r_idx) == i) begin
                w_dp = r_snap_dp[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_shifted[3:0]),
        .i_dp     (w_dp),
        .i_blank  (r_snap_void || w_lzb_blank),
        .o_seg    (w_seg_dec)
    );

    // Registered drivers: dark during reset, global blank, or before the first snapshot
    always_ff @(posedge CLK) begin
        if (RST || Blank || !r_valid) begin
            r_an  <= {NUM_DIGITS{c_an_off}};
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an_drive;
            r_seg <= w_seg_dec;
        end
    end

    // Frame-start strobe follows the snapshot load by one cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
        end
    end

    assign AN         = r_an;
    assign Seg        = r_seg;
    assign FrameStart = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (DIV_TERM=4, 4 digits)
//                with a second instance built for a single page.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int c_div   = 4;
    localparam int c_nd    = 4;
    localparam int c_frame = c_div * c_nd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] data;
    logic        sel;
    logic [3:0]  dp;
    logic        lzb_en;
    logic        blank;
    logic [15:0] data1;
    logic        sel1;
    logic [3:0]  an, an1;
    logic [7:0]  seg, seg1;
    logic        fs, fs1;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .NUM_PAGES(2), .DIV_TERM(4)) u_dut (
        .CLK(clk), .RST(rst), .Data(data), .Sel(sel), .Dp(dp), .LzbEn(lzb_en),
        .Blank(blank), .AN(an), .Seg(seg), .FrameStart(fs)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(4), .NUM_PAGES(1), .DIV_TERM(4)) u_dut1 (
        .CLK(clk), .RST(rst), .Data(data1), .Sel(sel1), .Dp(dp), .LzbEn(lzb_en),
        .Blank(blank), .AN(an1), .Seg(seg1), .FrameStart(fs1)
    );

    // Standard hex font, active-low, dp dark
    function automatic logic [7:0] ref_hex(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Expected segments of digit i of a 4-digit page
    function automatic logic [7:0] ref_digit(input logic [15:0] page, input logic [3:0] dps,
                                             input logic lzb, input logic void_page, input int i);
        logic [15:0] upper;
        logic [7:0]  s;
        upper = page >> (4 * i);
        if (void_page) return 8'hFF;
        if (lzb && i > 0 && upper == 16'h0000) return 8'hFF;
        s = ref_hex(upper[3:0]);
        if (dps[i]) s[7] = 1'b0;
        return s;
    endfunction

    // Reference model: time since reset release determines slot, digit and frame boundaries
    int          k;
    logic        m_valid;
    logic [15:0] m_page0, m_page1;
    logic [3:0]  m_dp;
    logic        m_lzb, m_void1;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg, exp_seg1;
    logic        exp_fs;

    always @(posedge clk) begin : p_model
        int idx;
        if (rst) begin
            k = 0; m_valid = 1'b0;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_seg1 = 8'hFF; exp_fs = 1'b0;
        end else begin
            idx = (k / c_div) % c_nd;
            if (blank || !m_valid) begin
                exp_an = 4'hF; exp_seg = 8'hFF; exp_seg1 = 8'hFF;
            end else begin
                exp_an   = ~(4'b0001 << idx);
                exp_seg  = ref_digit(m_page0, m_dp, m_lzb, 1'b0, idx);
                exp_seg1 = ref_digit(m_page1, m_dp, m_lzb, m_void1, idx);
            end
            exp_fs = (k == 0) || (k % c_frame == c_frame - 1);
            if (exp_fs) begin
                m_valid = 1'b1;
                m_page0 = sel ? data[31:16] : data[15:0];
                m_page1 = data1;
                m_dp    = dp;
                m_lzb   = lzb_en;
                m_void1 = (sel1 != 1'b0);
            end
            k = k + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; sel1 = 1'b0; data = 32'h8765_4321; data1 = 16'h4321;
        dp = 4'h0; lzb_en = 1'b0; blank = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0}) begin
                n_errors++;
                $display("FAIL reset: an=%h seg=%h fs=%b an1=%h seg1=%h fs1=%b, required F FF 0 F FF 0",
                         an, seg, fs, an1, seg1, fs1);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan();
        logic [7:0] lit;
        repeat (2 * c_frame + 4) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL basic_model: got %h %h %b %h %h %b, expected %h %h %b %h %h %b",
                         an, seg, fs, an1, seg1, fs1, exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs);
            end
            if (an != 4'hF) begin
                case (an)
                    4'b1110: lit = 8'hF9;
                    4'b1101: lit = 8'hA4;
                    4'b1011: lit = 8'hB0;
                    4'b0111: lit = 8'h99;
                    default: lit = 8'h00;
                endcase
                n_checks++;
                if (seg !== lit) begin
                    n_errors++;
                    $display("FAIL basic_literal: an=%b seg=%h, required %h", an, seg, lit);
                end
            end
        end
    endtask

    task automatic test_page_switch();
        int pulses = 0;
        logic [7:0] lit;
        for (int i = 0; i < c_frame && (k % c_frame) != 6; i++) @(negedge clk);
        sel = 1'b1;
        repeat (c_frame) begin
            @(negedge clk);
            pulses += int'(fs);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL page_model: got %h %h %b, expected %h %h %b", an, seg, fs, exp_an, exp_seg, exp_fs);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL page_framestart: pulses=%0d, required 1", pulses);
        end
        repeat (c_frame) begin
            @(negedge clk);
            case (an)
                4'b1110: lit = 8'h92;
                4'b1101: lit = 8'h82;
                4'b1011: lit = 8'hF8;
                4'b0111: lit = 8'h80;
                default: lit = 8'h00;
            endcase
            n_checks++;
            if (seg !== lit) begin
                n_errors++;
                $display("FAIL page_literal: an=%b seg=%h, required %h", an, seg, lit);
            end
        end
    endtask

    task automatic test_lzb(input logic [15:0] page, input logic [3:0] dps);
        logic [7:0] lit;
        lzb_en = 1'b1; sel = 1'b0; data[15:0] = page; dp = dps;
        repeat (c_frame + 2) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL lzb_model: got %h %h %b, expected %h %h %b", an, seg, fs, exp_an, exp_seg, exp_fs);
            end
        end
        repeat (c_frame) begin
            @(negedge clk);
            if (page == 16'h0040) begin
                case (an)
                    4'b1110: lit = 8'hC0;
                    4'b1101: lit = 8'h99;
                    default: lit = 8'hFF;
                endcase
            end else begin
                lit = (an == 4'b1110) ? 8'hC0 : 8'hFF;
            end
            n_checks++;
            if (seg !== lit) begin
                n_errors++;
                $display("FAIL lzb_literal: page=%h an=%b seg=%h, required %h", page, an, seg, lit);
            end
        end
        lzb_en = 1'b0; dp = 4'h0; data[15:0] = 16'h4321;
    endtask

    task automatic test_blank();
        blank = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, an1, seg1} !== {4'hF, 8'hFF, 4'hF, 8'hFF}) begin
                n_errors++;
                $display("FAIL blank_dark: an=%h seg=%h an1=%h seg1=%h, required F FF F FF", an, seg, an1, seg1);
            end
        end
        blank = 1'b0;
        repeat (c_frame + 4) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL blank_resume: got %h %h %b, expected %h %h %b", an, seg, fs, exp_an, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_invalid_page();
        sel1 = 1'b1;
        repeat (c_frame + 2) @(negedge clk);
        repeat (c_frame) begin
            @(negedge clk);
            n_checks++;
            if (seg1 !== 8'hFF || an1 === 4'hF || an1 !== exp_an) begin
                n_errors++;
                $display("FAIL invalid_page: an1=%b seg1=%h, required an1=%b seg1=FF", an1, seg1, exp_an);
            end
        end
        sel1 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < c_frame && (k % c_frame) != 9; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({an, seg, fs} !== {4'hF, 8'hFF, 1'b0}) begin
            n_errors++;
            $display("FAIL midreset_dark: an=%h seg=%h fs=%b, required F FF 0", an, seg, fs);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL midreset_model: got %h %h %b, expected %h %h %b", an, seg, fs, exp_an, exp_seg, exp_fs);
            end
        end
        n_checks++;
        if (an !== 4'b1110 || seg !== 8'hF9) begin
            n_errors++;
            $display("FAIL midreset_digit0: an=%b seg=%h, required 1110 F9", an, seg);
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, fs, an1, seg1, fs1} !== {exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs}) begin
                n_errors++;
                $display("FAIL random_model: got %h %h %b %h %h %b, expected %h %h %b %h %h %b",
                         an, seg, fs, an1, seg1, fs1, exp_an, exp_seg, exp_fs, exp_an, exp_seg1, exp_fs);
            end
            if ($urandom_range(3) == 0) data  = $urandom;
            if ($urandom_range(3) == 0) data1 = 16'($urandom);
            if ($urandom_range(7) == 0) data[15:0] = 16'($urandom_range(255));
            if ($urandom_range(7) == 0) sel   = 1'($urandom);
            if ($urandom_range(7) == 0) sel1  = 1'($urandom);
            if ($urandom_range(7) == 0) dp    = 4'($urandom);
            if ($urandom_range(7) == 0) lzb_en = 1'($urandom);
            blank = ($urandom_range(9) == 0);
            rst   = ($urandom_range(99) == 0);
        end
        rst = 1'b0; blank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_page_switch();
        test_lzb(16'h0040, 4'b1000);
        test_lzb(16'h0000, 4'b1110);
        test_blank();
        test_invalid_page();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter NUM_PAGES, default 2: number of selectable data pages, range 1..4.
REQ-003 Parameter DIV_TERM, default 262144: CLK cycles per digit slot, minimum 2.
REQ-004 CLK  input  1  sole clock; all state on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 Data  input  4*NUM_DIGITS*NUM_PAGES  hex nibbles; page p occupies bits [4*NUM_DIGITS*(p+1)-1 : 4*NUM_DIGITS*p]; digit 0 is the least-significant nibble of its page.
REQ-007 Sel  input  max(1,clog2(NUM_PAGES))  page select.
REQ-008 Dp  input  NUM_DIGITS  per-digit decimal point, 1 = lit.
REQ-009 LzbEn  input  1  leading-zero blanking enable.
REQ-010 Blank  input  1  blanks the whole display.
REQ-011 AN  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-012 Seg  output  8  segments, active-low; Seg[6:0] = g..a, Seg[7] = dp.
REQ-013 FrameStart  output  1  one-cycle pulse when a new snapshot is latched.

Function
REQ-014 The prescaler SHALL count 0..DIV_TERM-1 and wrap to 0; tick is asserted in the cycle the count equals DIV_TERM-1.
REQ-015 The digit index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-016 A snapshot of the selected page, Dp and LzbEn SHALL be latched in the first cycle after RST deasserts and on every tick where the index wraps to 0; no input change SHALL alter a frame mid-scan (no tearing).
REQ-017 FrameStart SHALL pulse high for exactly one cycle, in the cycle after each snapshot load.
REQ-018 If Sel >= NUM_PAGES, the snapshot SHALL load as all-blank digits with dp off.
REQ-019 The nibble SHALL decode as standard hex 0-F (0 = a..f lit, 1 = b,c lit, ..., F = a,e,f,g lit).
REQ-020 With snapshot LzbEn = 1, each zero digit with no non-zero digit above it SHALL be blanked, dp included; digit 0 is never blanked by this rule.
REQ-021 AN and Seg SHALL be registered and reflect the new index one cycle after the tick (latency 1).
REQ-022 Blank = 1 SHALL drive AN to all-ones and Seg to 8'hFF from the next cycle; scanning and snapshots continue underneath, and release resumes at the current index.
REQ-023 With NUM_DIGITS = 1, AN SHALL stay 0 (unless blanked) and every tick SHALL be a frame wrap.

Reset
REQ-024 While RST is high: prescaler = 0, index = 0, snapshot = 0, AN = all-ones, Seg = 8'hFF, FrameStart = 0.
REQ-025 RST asserted mid-frame SHALL abort the frame; the scan restarts at digit 0 with a fresh snapshot per REQ-016.

Structure
REQ-026 A shared package seg7_pkg SHALL hold the 16-entry hex-to-segment constant table, SEG_OFF = 8'hFF, and the active-low polarity constants.
REQ-027 Decoding SHALL be a single sub-module seg7_hex_decode (4-bit nibble + dp + blank in, 8-bit active-low Seg out, combinational).

Verification (DIV_TERM = 4, NUM_DIGITS = 4, NUM_PAGES = 2)
REQ-028 Reset, then Data = 32'h8765_4321, Sel = 0 -> AN cycles 1110, 1101, 1011, 0111 every 4 cycles; Seg = 8'hF9, A4, B0, 99 for digits 0..3.
REQ-029 Sel changes 0 -> 1 mid-frame -> current frame completes with 4321; the next frame shows 8765, with FrameStart pulsing once at the boundary.
REQ-030 LzbEn = 1, page 0 = 16'h0040 -> digits 3 and 2 have Seg = 8'hFF; digit 1 shows 4 (8'h99); digit 0 shows 0 (8'hC0); page 0 = 16'h0000 -> only digit 0 is lit.
REQ-031 Blank pulsed for 6 cycles -> AN = 4'hF, Seg = 8'hFF in the following 6 cycles; the scan index after release matches an unblanked reference count.
REQ-032 Sel = 1 with NUM_PAGES = 1 rebuild -> all digits are blank at the next frame; RST for 1 cycle mid-frame -> AN = 4'hF during reset, then digit 0 is active 4 cycles after release.
